mem_access: RTL
===============

Name: mem_access

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits between the ex_mem pipeline register and the mem/wb pipeline register, and drives the mem_* inputs of that register.
- Non-memory instructions pass through with one-cycle registered latency.
- Loads and stores run a req/ack transaction on the data bus. During the transaction the block holds the pipeline stalled through ctrl.
- Handles big-endian MIPS byte-lane selection, load sign/zero extension, alignment checking and a bus timeout.

Parameters:
- TIMEOUT, 255: maximum cycles spent in BUS without ack before the access is aborted. Legal range is 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- ex_waddr  in  5  destination GPR address
- ex_wreg  in  1  GPR write enable
- ex_wdata  in  32  ALU result
- ex_hi  in  32  HI value
- ex_lo  in  32  LO value
- ex_whilo  in  1  HI/LO write enable
- ex_memop  in  4  access type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW (9-15 treated as none)
- ex_memaddr  in  32  effective byte address
- ex_memdata  in  32  store data (rt)
- stallreq  out  1  stall request to ctrl (combinational)
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address (byte address with [1:0]=0)
- bus_sel  out  4  byte enables; bit3 = bits 31:24
- bus_wdata  out  32  write data
- bus_rdata  in  32  read data, valid with ack
- bus_ack  in  1  transaction complete
- mem_waddr  out  5  to mem/wb register
- mem_wreg  out  1  to mem/wb register
- mem_wdata  out  32  to mem/wb register
- mem_hi  out  32  to mem/wb register
- mem_lo  out  32  to mem/wb register
- mem_whilo  out  1  to mem/wb register
- addr_err  out  1  one-cycle pulse: misaligned access dropped
- bus_err  out  1  one-cycle pulse: bus timeout

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all mem_* outputs 0; bus_req, bus_we, bus_sel, bus_addr, bus_wdata, addr_err, bus_err all 0; timeout counter 0. A reset during BUS drops bus_req immediately.
- Alignment rule: halfword accesses need addr[0]=0; word accesses need addr[1:0]=0; byte accesses are always aligned.
- IDLE, ex_memop none: at the next edge, mem_* <= ex_* (one-cycle latency). stallreq=0.
- IDLE, ex_memop is an access but misaligned: no bus cycle. At the next edge, mem_wreg=0, mem_whilo=0, and other mem_* take ex values. addr_err=1 for one cycle. stallreq=0.
- IDLE, aligned access:
  - stallreq=1 combinationally.
  - At the edge, latch op, waddr, lane and store data.
  - Drive bus_req=1, bus_we, bus_addr, bus_sel and bus_wdata from registers.
  - Clear the counter. State becomes BUS.
  - mem_wreg and mem_whilo are 0 (bubble).
- BUS: bus outputs are held stable. stallreq = !bus_ack. The counter increments each cycle without ack.
- BUS, bus_ack=1:
  - At the edge, bus_req=0 and state returns to IDLE.
  - Load: mem_wreg=latched ex_wreg, mem_waddr=latched waddr, mem_wdata=extracted value.
  - Store: mem_wreg=0.
  - mem_whilo=0.
- BUS, counter reaches TIMEOUT-1 with no ack: stallreq=0. At the edge, bus_req=0, state returns to IDLE, the output is a bubble, and bus_err pulses for one cycle. If ack and timeout occur in the same cycle, ack wins.
- Byte lanes (big-endian), by addr[1:0]:
  - Byte: 0→sel 1000 / bits 31:24, 1→0100 / 23:16, 2→0010 / 15:8, 3→0001 / 7:0.
  - Halfword: 0→1100 / bits 31:16, 2→0011 / 15:0.
  - Word: sel 1111.
- Store data: SB writes {4{data[7:0]}}, SH writes {2{data[15:0]}}, SW writes data.
- Load extension: LB and LH sign-extend; LBU and LHU zero-extend.
- Loads return data only through mem_wdata. No other HI/LO or ex forwarding happens inside this block.

Test Plan:
- ADD result passthrough: ex_waddr=5, ex_wreg=1, ex_wdata=0x1234, memop=0 → next cycle mem_wdata=0x1234, mem_wreg=1, stallreq never asserted.
- LB at addr 0x103, bus_rdata=0x000000F0, ack after 3 cycles → sel=0001, bus_addr=0x100, stallreq high 3 cycles, then mem_wdata=0xFFFFFFF0; repeat with LBU → 0x000000F0.
- SH at 0x202, data=0xAAAABEEF, immediate ack → bus_we=1, sel=0011, bus_wdata=0xBEEFBEEF, mem_wreg=0 afterwards.
- LW at 0x101 → no bus_req, addr_err pulses 1 cycle, mem_wreg=0, stallreq=0.
- TIMEOUT=4, LW with ack never asserted → bus_req high 4 cycles, then dropped, bus_err pulse, bubble output; a second test asserts ack in the 4th cycle → normal completion, no bus_err.
- rst=0 asserted in the 2nd BUS cycle → bus_req, stallreq and all mem_* go to 0 immediately; after release an ADD passes through normally.

Source files
------------

// File: rtl/mem_access.sv
// MIPS memory-access stage: registered passthrough for ALU ops, req/ack bus
// transaction with pipeline stall for loads/stores, alignment and timeout errors.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_memaddr,
    input  logic [31:0] ex_memdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [4:0]  mem_waddr,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUS} state_t;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  waddr_lat_q, waddr_lat_d;
    logic        wreg_lat_q, wreg_lat_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [4:0]  mem_waddr_q, mem_waddr_d;
    logic        mem_wreg_q, mem_wreg_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] mem_hi_q, mem_hi_d;
    logic [31:0] mem_lo_q, mem_lo_d;
    logic        mem_whilo_q, mem_whilo_d;
    logic        addr_err_q, addr_err_d;
    logic        bus_err_q, bus_err_d;

    logic        is_byte, is_half, is_word, is_store, is_acc, misaligned, start, timeout;
    logic [3:0]  sel_c;
    logic [31:0] st_data_c;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;

    always_comb begin
        is_byte    = (ex_memop == 4'd1) || (ex_memop == 4'd2) || (ex_memop == 4'd6);
        is_half    = (ex_memop == 4'd3) || (ex_memop == 4'd4) || (ex_memop == 4'd7);
        is_word    = (ex_memop == 4'd5) || (ex_memop == 4'd8);
        is_store   = (ex_memop >= 4'd6) && (ex_memop <= 4'd8);
        is_acc     = is_byte || is_half || is_word;
        misaligned = (is_half && ex_memaddr[0]) || (is_word && (ex_memaddr[1:0] != 2'b00));
        start      = is_acc && !misaligned;
        timeout    = (state_q == BUS) && !bus_ack && (cnt_q == CNT_LAST);
        sel_c      = 4'b1111;
        st_data_c  = ex_memdata;
        if (is_byte) begin
            sel_c     = 4'b1000 >> ex_memaddr[1:0];
            st_data_c = {4{ex_memdata[7:0]}};
        end else if (is_half) begin
            sel_c     = ex_memaddr[1] ? 4'b0011 : 4'b1100;
            st_data_c = {2{ex_memdata[15:0]}};
        end
    end

    // Big-endian lane extraction uses the lane latched at request time.
    always_comb begin
        case (lane_q)
            2'd0:    ld_b = bus_rdata[31:24];
            2'd1:    ld_b = bus_rdata[23:16];
            2'd2:    ld_b = bus_rdata[15:8];
            default: ld_b = bus_rdata[7:0];
        endcase
        ld_h = lane_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        case (op_q)
            4'd1:    ld_val = {{24{ld_b[7]}}, ld_b};
            4'd2:    ld_val = {24'b0, ld_b};
            4'd3:    ld_val = {{16{ld_h[15]}}, ld_h};
            4'd4:    ld_val = {16'b0, ld_h};
            default: ld_val = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            lane_q      <= '0;
            waddr_lat_q <= '0;
            wreg_lat_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            mem_waddr_q <= '0;
            mem_wreg_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
            mem_whilo_q <= 1'b0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            waddr_lat_q <= waddr_lat_d;
            wreg_lat_q  <= wreg_lat_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
            mem_whilo_q <= mem_whilo_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUS;
            BUS:     if (bus_ack || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        op_d        = op_q;
        lane_d      = lane_q;
        waddr_lat_d = waddr_lat_q;
        wreg_lat_d  = wreg_lat_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        mem_waddr_d = mem_waddr_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        mem_whilo_d = mem_whilo_q;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;
        if (state_q == IDLE) begin
            mem_waddr_d = ex_waddr;
            mem_wreg_d  = ex_wreg && !is_acc;
            mem_wdata_d = ex_wdata;
            mem_hi_d    = ex_hi;
            mem_lo_d    = ex_lo;
            mem_whilo_d = ex_whilo && !is_acc;
            addr_err_d  = is_acc && misaligned;
            if (start) begin
                op_d        = ex_memop;
                lane_d      = ex_memaddr[1:0];
                waddr_lat_d = ex_waddr;
                wreg_lat_d  = ex_wreg;
                bus_req_d   = 1'b1;
                bus_we_d    = is_store;
                bus_addr_d  = {ex_memaddr[31:2], 2'b00};
                bus_sel_d   = sel_c;
                bus_wdata_d = is_store ? st_data_c : '0;
                cnt_d       = '0;
            end
        end else begin
            mem_wreg_d  = 1'b0;
            mem_whilo_d = 1'b0;
            if (bus_ack) begin
                bus_req_d = 1'b0;
                cnt_d     = '0;
                if (!bus_we_q) begin
                    mem_wreg_d  = wreg_lat_q;
                    mem_waddr_d = waddr_lat_q;
                    mem_wdata_d = ld_val;
                end
            end else if (timeout) begin
                bus_req_d = 1'b0;
                cnt_d     = '0;
                bus_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Stall is forced low while reset is held so ctrl sees no request from a dead stage.
    always_comb begin
        stallreq = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE:    stallreq = start;
                BUS:     stallreq = !bus_ack && !timeout;
                default: stallreq = 1'b0;
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wreg  = mem_wreg_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_hi    = mem_hi_q;
    assign mem_lo    = mem_lo_q;
    assign mem_whilo = mem_whilo_q;
    assign addr_err  = addr_err_q;
    assign bus_err   = bus_err_q;

endmodule
